serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl_pkg.sv | 12 +
 rtl/serial_adder_ctrl_if.sv | 25 ++
 rtl/fulladder.sv | 11 +
 rtl/serial_adder_ctrl.sv | 110 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requesting unit and the serial adder.
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/fulladder.sv
// Single-bit full adder used as the shared serial datapath.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full adder reused WIDTH times, LSB first.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
)
(
    input logic           clk,
    input logic           rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int unsigned     CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic             busy_q;
    logic             done_q;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CNT_W-1:0] cnt;

    logic             fa_sum;
    logic             fa_carry;

    fulladder u_fa (
        .a     (sh_a[0]),
        .b     (sh_b[0]),
        .c     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Next-state decode plus accept/commit strobes for the datapath.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    last_bit   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; busy/done are flopped from the next state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next != IDLE);
            done_q <= (state_next == DONE);
        end
    end

    // Operand shifters, carry flop, bit counter and committed result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a   <= '0;
            sh_b   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            sh_a  <= bus.a;
            sh_b  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            res   <= '0;
        end else if (state == RUN) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            res   <= {fa_sum, res[WIDTH-1:1]};
            carry <= fa_carry;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) begin
                sum_q  <= {fa_sum, res[WIDTH-1:1]};
                cout_q <= fa_carry;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized checks of serial_adder_ctrl against an arithmetic model.
module tb_serial_adder_ctrl;
    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [W-1:0] held_sum;
    logic         held_cout;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
            chk({tag, "_done"}, 32'(bus.done), 32'd0);
            chk({tag, "_sum"},  32'(bus.sum),  32'(held_sum));
            chk({tag, "_cout"}, 32'(bus.cout), 32'(held_cout));
        end
    endtask

    // One operation; poke > 0 pulses start with new operands on that cycle of the run.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input int poke, input string tag);
        logic [W:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        tick();
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
        chk({tag, "_busy0"}, 32'(bus.busy), 32'd1);
        chk({tag, "_done0"}, 32'(bus.done), 32'd0);
        for (int n = 1; n <= int'(W) + 1; n++) begin
            if (n == poke) begin
                bus.start = 1'b1;
                bus.a     = '1;
                bus.b     = W'($urandom);
            end else if (n == poke + 1) begin
                bus.start = 1'b0;
            end
            tick();
            if (n < int'(W)) begin
                chk({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
                chk({tag, "_done_run"}, 32'(bus.done), 32'd0);
                chk({tag, "_sum_run"},  32'(bus.sum),  32'(held_sum));
                chk({tag, "_cout_run"}, 32'(bus.cout), 32'(held_cout));
            end else if (n == int'(W)) begin
                chk({tag, "_done"}, 32'(bus.done), 32'd1);
                chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
                chk({tag, "_sum"},  32'(bus.sum),  32'(exp[W-1:0]));
                chk({tag, "_cout"}, 32'(bus.cout), 32'(exp[W]));
            end else begin
                chk({tag, "_done_end"}, 32'(bus.done), 32'd0);
                chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
            end
        end
        held_sum  = exp[W-1:0];
        held_cout = exp[W];
        idle_check(1, {tag, "_after"});
    endtask

    initial begin
        logic [W:0] exp1;
        logic [W:0] exp2;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        vectors     = 0;
        miscompares = 0;
        held_sum    = '0;
        held_cout   = 1'b0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.cin     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        idle_check(5, "reset_idle");

        run_op(8'h35, 8'h4A, 1'b0, 0, "op35_4a");
        run_op(8'hFF, 8'h01, 1'b1, 0, "opff_01");
        run_op(8'h80, 8'h80, 1'b0, 0, "op80_80");
        idle_check(10, "hold");

        run_op(8'h12, 8'h34, 1'b0, 3, "ignore_run");
        run_op(8'h0F, 8'hF0, 1'b1, int'(W), "ignore_done");

        // Reset three cycles into an operation discards it.
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b0;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        held_sum  = '0;
        held_cout = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_sum",  32'(bus.sum),  32'd0);
        chk("midrst_cout", 32'(bus.cout), 32'd0);
        idle_check(12, "midrst_idle");
        run_op(8'h01, 8'h01, 1'b0, 0, "after_rst");

        // Reset beats a simultaneous start.
        rst = 1'b1; bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22;
        tick();
        rst = 1'b0; bus.start = 1'b0;
        held_sum  = '0;
        held_cout = 1'b0;
        chk("rst_start_busy", 32'(bus.busy), 32'd0);
        idle_check(3, "rst_start_idle");

        // Start held high: next accept lands on the first IDLE edge after DONE.
        exp1 = {1'b0, 8'h9C} + {1'b0, 8'h77} + 9'd1;
        exp2 = {1'b0, 8'h40} + {1'b0, 8'hC1} + 9'd0;
        bus.start = 1'b1; bus.a = 8'h9C; bus.b = 8'h77; bus.cin = 1'b1;
        tick();
        bus.a = 8'h40; bus.b = 8'hC1; bus.cin = 1'b0;
        for (int n = 1; n <= 2 * int'(W) + 3; n++) begin
            tick();
            if (n == int'(W)) begin
                chk("held_done1", 32'(bus.done), 32'd1);
                chk("held_sum1",  32'(bus.sum),  32'(exp1[W-1:0]));
                chk("held_cout1", 32'(bus.cout), 32'(exp1[W]));
            end else if (n == int'(W) + 1) begin
                chk("held_gap_busy", 32'(bus.busy), 32'd0);
            end else if (n == int'(W) + 2) begin
                chk("held_reaccept", 32'(bus.busy), 32'd1);
                bus.start = 1'b0;
            end else if (n == 2 * int'(W) + 2) begin
                chk("held_done2", 32'(bus.done), 32'd1);
                chk("held_sum2",  32'(bus.sum),  32'(exp2[W-1:0]));
                chk("held_cout2", 32'(bus.cout), 32'(exp2[W]));
            end else if (n == 2 * int'(W) + 3) begin
                chk("held_end_busy", 32'(bus.busy), 32'd0);
            end else begin
                chk("held_no_done", 32'(bus.done), 32'd0);
            end
        end
        held_sum  = exp2[W-1:0];
        held_cout = exp2[W];

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, W)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
